rr_mux_4_to_1: RTL and testbench

//   Collects four input channels onto one output stream. It is the gathering end

---
 rtl/rr_mux_4_to_1.sv | 93 +++++++++
 tb/tb_rr_mux_4_to_1.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_4_to_1.sv
// Round-robin 4:1 gather: arbitrates four valid/ready inputs into one registered word tagged with its channel.
// Latency: 1 clock from input accept to o_Valid.
// Backpressure: o_Ready is held low while the output register is full and i_Ready is low; held words stay stable.
module rr_mux_4_to_1 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic [3:0]            i_Valid,
    input  logic [DATA_WIDTH-1:0] i_Data0,
    input  logic [DATA_WIDTH-1:0] i_Data1,
    input  logic [DATA_WIDTH-1:0] i_Data2,
    input  logic [DATA_WIDTH-1:0] i_Data3,
    output logic [3:0]            o_Ready,
    output logic                  o_Valid,
    output logic [DATA_WIDTH-1:0] o_Data,
    output logic                  o_Sel1,
    output logic                  o_Sel0,
    input  logic                  i_Ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0]            sel;
        logic [DATA_WIDTH-1:0] dat;
    } word_t;

    state_t                state;
    word_t                 out_word;
    logic [1:0]            ptr;
    logic                  load_en;
    logic                  winner_vld;
    logic [1:0]            winner;
    logic [1:0]            idx;
    logic [DATA_WIDTH-1:0] win_dat;

    assign load_en = (state == EMPTY) || i_Ready;

    // First requesting channel at or after ptr, wrapping around.
    always_comb begin
        winner_vld = 1'b0;
        winner     = 2'd0;
        idx        = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!winner_vld && i_Valid[idx]) begin
                winner_vld = 1'b1;
                winner     = idx;
            end
        end
    end

    always_comb begin
        win_dat = i_Data0;
        case (winner)
            2'd0: win_dat = i_Data0;
            2'd1: win_dat = i_Data1;
            2'd2: win_dat = i_Data2;
            2'd3: win_dat = i_Data3;
            default: win_dat = i_Data0;
        endcase
    end

    assign o_Ready = (load_en && winner_vld && !i_Reset) ? (4'b0001 << winner) : 4'b0000;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state    <= EMPTY;
            out_word <= '0;
            ptr      <= 2'd0;
        end else if (load_en) begin
            // A consumed word is replaced in the same edge when a channel wins.
            if (winner_vld) begin
                state        <= FULL;
                out_word.sel <= winner;
                out_word.dat <= win_dat;
                ptr          <= winner + 2'd1;
            end else begin
                state <= EMPTY;
            end
        end
    end

    assign o_Valid = (state == FULL);
    assign o_Data  = out_word.dat;
    assign o_Sel1  = out_word.sel[1];
    assign o_Sel0  = out_word.sel[0];

endmodule

// File: tb/tb_rr_mux_4_to_1.sv
// Directed and randomized loopback bench for the round-robin 4:1 gather.
module tb_rr_mux_4_to_1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] i_valid;
    logic [7:0] dat [4];
    logic [3:0] o_ready;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_sel1;
    logic       o_sel0;
    logic       i_ready;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] sb [4][$];
    logic [7:0] seq;
    logic [7:0] exp_word;
    logic [1:0] ch;
    logic [3:0] acc;

    always #5 clk = ~clk;

    rr_mux_4_to_1 #(.DATA_WIDTH(8)) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .i_Valid (i_valid),
        .i_Data0 (dat[0]),
        .i_Data1 (dat[1]),
        .i_Data2 (dat[2]),
        .i_Data3 (dat[3]),
        .o_Ready (o_ready),
        .o_Valid (o_valid),
        .o_Data  (o_data),
        .o_Sel1  (o_sel1),
        .o_Sel0  (o_sel0),
        .i_Ready (i_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
        chk({tag, "_valid"}, {31'd0, o_valid}, {31'd0, v});
        chk({tag, "_data"}, {24'd0, o_data}, {24'd0, d});
        chk({tag, "_sel"}, {30'd0, o_sel1, o_sel0}, {30'd0, s});
    endtask

    initial begin
        rst = 1'b1;
        i_valid = 4'b1111;
        i_ready = 1'b1;
        for (int n = 0; n < 4; n++) dat[n] = 8'h10 + 8'(n);
        #1;
        chk("rst_ready_low", {28'd0, o_ready}, 32'h0);
        tick();
        tick();
        chk_out("reset", 1'b0, 8'h00, 2'd0);
        chk("rst_ready_low2", {28'd0, o_ready}, 32'h0);

        // 1: single request on channel 1
        rst = 1'b0;
        i_valid = 4'b0010;
        dat[1] = 8'hA5;
        #1;
        chk("t1_ready", {28'd0, o_ready}, 32'h2);
        tick();
        i_valid = 4'b0000;
        #1;
        chk_out("t1_out", 1'b1, 8'hA5, 2'd1);
        chk("t1_ready_idle", {28'd0, o_ready}, 32'h0);
        tick();
        chk("t1_drain", {31'd0, o_valid}, 32'h0);

        // 2: all channels requesting, full throughput from ptr 0
        rst = 1'b1;
        dat[1] = 8'h11;
        tick();
        rst = 1'b0;
        i_valid = 4'b1111;
        #1;
        chk("t2_first_ready", {28'd0, o_ready}, 32'h1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_out("t2_rr", 1'b1, 8'h10 + 8'(k % 4), 2'(k % 4));
        end

        // 3: backpressure holds the word (ch1) and blocks grants
        i_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_ready_blocked", {28'd0, o_ready}, 32'h0);
            tick();
            chk_out("t3_hold", 1'b1, 8'h11, 2'd1);
        end
        i_ready = 1'b1;
        #1;
        chk("t3_release_ready", {28'd0, o_ready}, 32'h4);
        tick();
        chk_out("t3_next", 1'b1, 8'h12, 2'd2);

        // 4: only channel 3, ptr wraps to 0 and ch3 wins again
        i_valid = 4'b1000;
        #1;
        chk("t4_ready_a", {28'd0, o_ready}, 32'h8);
        tick();
        chk_out("t4_first", 1'b1, 8'h13, 2'd3);
        dat[3] = 8'h33;
        #1;
        chk("t4_ready_wrap", {28'd0, o_ready}, 32'h8);
        tick();
        chk_out("t4_wrap", 1'b1, 8'h33, 2'd3);

        // 5: reset while full and stalled
        i_ready = 1'b0;
        i_valid = 4'b1111;
        rst = 1'b1;
        #1;
        chk("t5_ready_in_rst", {28'd0, o_ready}, 32'h0);
        tick();
        chk_out("t5_cleared", 1'b0, 8'h00, 2'd0);
        rst = 1'b0;
        #1;
        chk("t5_ready_ch0", {28'd0, o_ready}, 32'h1);
        tick();
        chk_out("t5_first_grant", 1'b1, 8'h10, 2'd0);

        i_valid = 4'b0000;
        i_ready = 1'b1;
        tick();
        chk("pre_rand_empty", {31'd0, o_valid}, 32'h0);

        // 6: random loopback through a channel-select demux scoreboard
        seq = 8'h00;
        for (int n = 0; n < 4; n++) begin
            i_valid[n] = 1'($urandom_range(0, 1));
            dat[n] = seq;
            seq++;
        end
        i_ready = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 10100; cyc++) begin
            @(negedge clk);
            chk("rand_onehot", {31'd0, $onehot0(o_ready)}, 32'h1);
            chk("rand_ready_req", {28'd0, o_ready & ~i_valid}, 32'h0);
            if (o_valid && i_ready) begin
                ch = {o_sel1, o_sel0};
                if (sb[ch].size() == 0) begin
                    chk("demux_extra", 32'h1, 32'h0);
                end else begin
                    exp_word = sb[ch].pop_front();
                    chk("demux_word", {24'd0, o_data}, {24'd0, exp_word});
                end
            end
            acc = i_valid & o_ready;
            for (int n = 0; n < 4; n++)
                if (acc[n]) sb[n].push_back(dat[n]);
            @(posedge clk);
            #1;
            for (int n = 0; n < 4; n++) begin
                if (acc[n] || !i_valid[n]) begin
                    // last 100 cycles stop new requests so everything drains
                    i_valid[n] = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
                    dat[n] = seq;
                    seq++;
                end
            end
            i_ready = (cyc < 10000) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        for (int n = 0; n < 4; n++)
            chk("rand_drained", sb[n].size(), 32'h0);
        chk("rand_no_pending", {27'd0, i_valid, o_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
